perip_timecmp: RTL and testbench
================================

Name: perip_timecmp

Overview:
Memory-mapped timer-compare/interrupt peripheral, directly downstream of the microsecond time counter peripheral. It consumes the 64-bit free-running microsecond count and holds a 64-bit compare value. It raises a level interrupt to the core when the time reaches the compare value. It supports one-shot and periodic auto-reload modes, an atomic 64-bit compare update, and a saturating missed-event counter. It sits on the same peripheral bus as the time peripheral and uses the same ena/rw/addr/rdata/wdata access style.

Parameters:
DW, 32, bus data width; all registers are DW bits, fixed at 32.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
ena  in  1  bus access strobe for this peripheral.
rw  in  1  1 = write, 0 = read; qualified by ena.
addr  in  32  byte address; addr[4:2] selects the word; other bits are ignored.
wdata  in  32  write data.
rdata  out  32  registered read data.
time_i  in  64  microsecond count from the time counter.
irq  out  1  timer interrupt, registered level.

Behaviour:
- Register map (addr[4:2]):
  - 0 CMP_LO: write goes to lo_shadow only; read returns committed cmp[31:0].
  - 1 CMP_HI: write commits cmp <= {wdata, lo_shadow} atomically; read returns cmp[63:32].
  - 2 CTRL: bit0 EN, bit1 IE, bit2 PERIODIC; other bits read 0.
  - 3 PERIOD: 32-bit reload delta, read/write.
  - 4 STATUS: bit0 PENDING; writing 1 to bit0 clears it; writing 0 has no effect.
  - 5 MISSED: saturating count, read-only value; any write clears it to 0.
  - 6, 7: reads return 0; writes are ignored.
- Reset (rst=1 at a clk edge):
  - cmp = lo_shadow = 64'hFFFF_FFFF_FFFF_FFFF (lo_shadow low 32 bits all ones).
  - CTRL = 0, PERIOD = 0, PENDING = 0, MISSED = 0.
  - time_q = 0, match_q = 0, rdata = 0, irq = 0.
  - Reset overrides any same-cycle bus access. Reset mid-operation drops PENDING and deasserts irq the next cycle.
- Read: when ena=1 and rw=0, rdata <= selected register at the edge; data is valid one cycle later. rdata holds its value when there is no read.
- Time pipeline: time_q <= time_i every cycle.
- match = EN && (time_q >= cmp), unsigned 64-bit compare.
- match_q <= match every cycle.
- Event definition:
  - PERIODIC=0: event = match && !match_q (rising edge only).
  - PERIODIC=1: event = match, every cycle it holds.
- On event:
  - PENDING <= 1.
  - If PENDING was already 1 and is not being cleared this cycle: MISSED <= MISSED+1, saturating at 32'hFFFF_FFFF.
  - If PERIODIC=1: cmp <= cmp + {32'b0, PERIOD}, modulo 2^64 (wraps silently).
- PERIOD=0 in periodic mode: cmp does not move, an event fires every cycle while match holds, and MISSED increments each cycle after the first.
- irq <= PENDING && IE, registered, so irq follows PENDING by one cycle.
- Priorities within one cycle:
  - STATUS clear and event together: PENDING ends at 1, and MISSED does not increment.
  - CMP_HI write and periodic reload together: the bus write wins and the reload is discarded.
  - MISSED write-clear and increment together: MISSED ends at 0.
  - Clearing EN stops new events; it does not clear PENDING.
- time_i wrap from 2^64-1 to 0 is not special-cased; the compare re-evaluates naturally.
- A write with rw=1 does not update rdata.

Test Plan:
- Reset, then read words 0..7: CMP_LO/HI = FFFF_FFFF, all others 0, irq = 0.
- One-shot mode:
  - Stimulus: write CMP_LO=100, CMP_HI=0, CTRL=3; ramp time_i from 90 by 1 per cycle.
  - Response: PENDING sets 2 cycles after time_i=100 is presented, irq asserts 1 cycle after that, MISSED stays 0.
  - Then write STATUS=1: irq drops 2 cycles later and does not re-fire while time stays above 100.
- Atomic update: with cmp=FFFF_FFFF_FFFF_FFFF and time_i=50, write CMP_LO=10 only → no event; then write CMP_HI=0 → event fires, cmp reads 0000_0000_0000_000A.
- Periodic mode:
  - Stimulus: CTRL=7, PERIOD=10, cmp=100; ramp time_i without clearing STATUS.
  - Response: events at 100, 110, 120; cmp reads 130; MISSED=2.
  - Then write STATUS=1 in the same cycle as the event at 130: PENDING stays 1 and MISSED stays 2.
- Wrap and saturation:
  - cmp = FFFF_FFFF_FFFF_FFF8, PERIOD=16, periodic: after the event, cmp = 0000_0000_0000_0008.
  - Force MISSED to saturate (PERIOD=0, let it run beyond 2^32 events or preload via a test hook): it holds at FFFF_FFFF.
- Reset during a pending irq clears irq the next cycle and restores cmp to all ones.

Source files
------------

// File: rtl/perip_timecmp.sv
// perip_timecmp: 64-bit timer compare with one-shot/periodic events, level irq and missed-event count
module perip_timecmp #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          rw,
  input  logic [31:0]   addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic [63:0]   time_i,
  output logic          irq
);
  logic [63:0] cmp, time_q;
  logic [DW-1:0] lo_shadow, period, missed, rd_val;
  logic [2:0] sel;
  logic en, ie, periodic, pending, match_q;
  logic wr, rd, match, evt, clr;
  always_comb begin
    sel = addr[4:2];
    wr = ena && rw;
    rd = ena && !rw;
    match = en && (time_q >= cmp);
    evt = match && (periodic || !match_q);
    clr = wr && sel == 3'd4 && wdata[0];
    rd_val = sel == 3'd0 ? cmp[31:0] :
             sel == 3'd1 ? cmp[63:32] :
             sel == 3'd2 ? {29'b0, periodic, ie, en} :
             sel == 3'd3 ? period :
             sel == 3'd4 ? {31'b0, pending} :
             sel == 3'd5 ? missed : '0;
  end
  // Bus writes take priority over reload and missed-count increments in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp <= '1;
      lo_shadow <= '1;
      {periodic, ie, en} <= '0;
      period <= '0;
      pending <= 1'b0;
      missed <= '0;
      time_q <= '0;
      match_q <= 1'b0;
      rdata <= '0;
      irq <= 1'b0;
    end else begin
      time_q <= time_i;
      match_q <= match;
      irq <= pending && ie;
      if (rd) rdata <= rd_val;
      if (wr && sel == 3'd0) lo_shadow <= wdata;
      if (wr && sel == 3'd1) cmp <= {wdata, lo_shadow};
      else if (evt && periodic) cmp <= cmp + {32'b0, period};
      if (wr && sel == 3'd2) {periodic, ie, en} <= wdata[2:0];
      if (wr && sel == 3'd3) period <= wdata;
      if (evt) pending <= 1'b1;
      else if (clr) pending <= 1'b0;
      if (wr && sel == 3'd5) missed <= '0;
      else if (evt && pending && !clr && missed != '1) missed <= missed + 32'd1;
    end
  end
endmodule

// File: tb/tb_perip_timecmp.sv
// tb_perip_timecmp: directed register/irq checks with a read-data scoreboard
module tb_perip_timecmp;
  logic clk = 0, rst = 1, ena = 0, rw = 0, irq;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [63:0] time_i = 0;
  logic ramp = 0, rd_q = 0;
  logic [31:0] exp_q[$];
  string name_q[$];
  int ncmp = 0, nfail = 0;

  perip_timecmp dut (.clk(clk), .rst(rst), .ena(ena), .rw(rw), .addr(addr),
                     .wdata(wdata), .rdata(rdata), .time_i(time_i), .irq(irq));

  always #5 clk = ~clk;

  always @(posedge clk) rd_q <= ena && !rw && !rst;

  always @(negedge clk) begin
    if (rd_q) begin
      ncmp++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_read: got %h, no expectation queued", rdata);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rdata !== e) begin
          nfail++;
          $display("FAIL %s: got %h expected %h", n, rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp) time_i = time_i + 64'd1;
  endtask

  task automatic bus(input logic w, input int a, input logic [31:0] d);
    ena = 1; rw = w; addr = 32'(a) << 2; wdata = d;
    tick();
    ena = 0; rw = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus(1, a, d);
  endtask

  task automatic rd(input int a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    bus(0, a, 0);
  endtask

  task automatic chk_irq(input logic e, input string n);
    ncmp++;
    if (irq !== e) begin
      nfail++;
      $display("FAIL %s: irq got %b expected %b", n, irq, e);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_irq(0, "reset_irq");
    rd(0, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(1, 32'hFFFF_FFFF, "rst_cmp_hi");
    for (int i = 2; i < 8; i++) rd(i, 0, $sformatf("rst_word%0d", i));
    // one-shot
    wr(0, 100); wr(1, 0); wr(2, 3);
    time_i = 90; ramp = 1;
    for (int i = 0; i < 40 && time_i != 100; i++) tick();
    tick(); chk_irq(0, "os_irq_p1");
    tick(); chk_irq(0, "os_irq_p2");
    tick(); chk_irq(1, "os_irq_p3");
    rd(4, 1, "os_pending");
    rd(5, 0, "os_missed");
    wr(4, 1);
    chk_irq(1, "os_irq_clr0");
    tick(); chk_irq(0, "os_irq_clr1");
    repeat (4) tick();
    chk_irq(0, "os_no_refire");
    rd(4, 0, "os_pending_clr");
    // atomic 64-bit update
    ramp = 0;
    wr(0, 32'hFFFF_FFFF); wr(1, 32'hFFFF_FFFF);
    time_i = 50;
    wr(4, 1);
    wr(0, 10);
    repeat (3) tick();
    rd(4, 0, "at_lo_only_no_event");
    wr(1, 0);
    repeat (2) tick();
    rd(4, 1, "at_event");
    rd(0, 10, "at_cmp_lo");
    rd(1, 0, "at_cmp_hi");
    chk_irq(1, "at_irq");
    // periodic
    wr(2, 0); wr(4, 1); wr(5, 0);
    wr(3, 10); wr(0, 100); wr(1, 0);
    wr(2, 7);
    time_i = 90; ramp = 1;
    for (int i = 0; i < 80 && time_i != 125; i++) tick();
    ramp = 0;
    rd(0, 130, "per_cmp_lo");
    rd(1, 0, "per_cmp_hi");
    rd(5, 2, "per_missed");
    rd(4, 1, "per_pending");
    ramp = 1;
    for (int i = 0; i < 20 && time_i != 130; i++) tick();
    tick();
    wr(4, 1);
    ramp = 0;
    rd(4, 1, "per_clr_vs_event_pending");
    rd(5, 2, "per_clr_vs_event_missed");
    rd(0, 140, "per_cmp_after_130");
    // 64-bit wrap on reload
    wr(2, 0); wr(4, 1); wr(5, 0);
    wr(3, 16); wr(0, 32'hFFFF_FFF8); wr(1, 32'hFFFF_FFFF);
    time_i = 64'hFFFF_FFFF_FFFF_FFF8;
    repeat (2) tick();
    wr(2, 5);
    wr(2, 0);
    rd(0, 8, "wrap_cmp_lo");
    rd(1, 0, "wrap_cmp_hi");
    // saturation with PERIOD=0
    wr(3, 0); wr(0, 0); wr(1, 0); wr(5, 0);
    wr(2, 5);
    repeat (3) tick();
    force dut.missed = 32'hFFFF_FFFD;
    tick();
    release dut.missed;
    repeat (5) tick();
    rd(5, 32'hFFFF_FFFF, "sat_missed");
    wr(5, 0);
    rd(5, 0, "missed_clear_wins");
    rd(0, 0, "p0_cmp_static");
    wr(2, 0);
    // reset while irq pending
    wr(2, 2);
    repeat (2) tick();
    chk_irq(1, "pre_reset_irq");
    rst = 1;
    tick();
    chk_irq(0, "reset_drops_irq");
    rst = 0;
    rd(0, 32'hFFFF_FFFF, "post_rst_cmp_lo");
    rd(1, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    rd(4, 0, "post_rst_pending");
    rd(2, 0, "post_rst_ctrl");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      ncmp++; nfail++;
      $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
